// File: rtl/me_pkg.sv
// Shared constants, state type and width helper for the motion-estimator scan sequencer.
package me_pkg;

  localparam int unsigned NUM_PE_DEF       = 16;
  localparam int unsigned BLOCK_CYCLES_DEF = 256;
  localparam int unsigned NUM_ROWS_DEF     = 16;
  localparam int unsigned VEC_W            = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } me_state_t;

  // Ceiling log2; used to size counters from parameters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = 32'(i) + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/me_scan_counter.sv
// Pixel counter (cnt) and search row (row) pair; cnt wraps every pass, row advances per pass.
module me_scan_counter
  import me_pkg::*;
#(
  parameter int unsigned PASS_LEN = BLOCK_CYCLES_DEF + NUM_PE_DEF,
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF,
  parameter int unsigned CNT_W    = clog2(PASS_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [VEC_W-1:0] row,
  output logic             pass_last,
  output logic             scan_last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] row_q, row_d;

  assign pass_last = (cnt_q == CNT_W'(PASS_LEN - 1));
  assign scan_last = (row_q == VEC_W'(NUM_ROWS - 1));

  // Next count: clear wins; the last pass wraps row back to 0 so DONE/IDLE see a zeroed pair.
  always_comb begin
    cnt_d = cnt_q;
    row_d = row_q;
    if (clear) begin
      cnt_d = '0;
      row_d = '0;
    end else if (en) begin
      if (pass_last) begin
        cnt_d = '0;
        row_d = scan_last ? '0 : row_q + VEC_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign cnt = cnt_q;
  assign row = row_q;

endmodule

// File: rtl/me_scan_control.sv
// Scan sequencer feeding the distortion comparator: IDLE/RUN/DONE FSM plus output decode
// of state, cnt and row. Define ME_SCAN_ABORT_EN to add the synchronous abort input.
module me_scan_control
  import me_pkg::*;
#(
  parameter  int unsigned NUM_PE       = NUM_PE_DEF,
  parameter  int unsigned BLOCK_CYCLES = BLOCK_CYCLES_DEF,
  parameter  int unsigned NUM_ROWS     = NUM_ROWS_DEF,
  localparam int unsigned ADDR_W       = clog2(BLOCK_CYCLES)
) (
`ifdef ME_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              CompStart,
  output logic [NUM_PE-1:0] PEready,
  output logic [VEC_W-1:0]  vectorX,
  output logic [VEC_W-1:0]  vectorY,
  output logic [NUM_PE-1:0] newDist,
  output logic [ADDR_W-1:0] AddressR,
  output logic              busy,
  output logic              completed
);

  localparam int unsigned PASS_LEN = BLOCK_CYCLES + NUM_PE;
  localparam int unsigned CNT_W    = clog2(PASS_LEN);

  me_state_t        state_q;
  logic [CNT_W-1:0] cnt;
  logic [VEC_W-1:0] row;
  logic             pass_last;
  logic             scan_last;
  logic             run;
  logic             abort_hit;
  logic             in_acc;
  logic [CNT_W-1:0] x_off;

  assign run = (state_q == RUN);

`ifdef ME_SCAN_ABORT_EN
  assign abort_hit = run && abort;
`else
  assign abort_hit = 1'b0;
`endif

  me_scan_counter #(
    .PASS_LEN (PASS_LEN),
    .NUM_ROWS (NUM_ROWS),
    .CNT_W    (CNT_W)
  ) u_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (!run || abort_hit),
    .en        (run),
    .cnt       (cnt),
    .row       (row),
    .pass_last (pass_last),
    .scan_last (scan_last)
  );

  // Scan FSM: start only sampled in IDLE, DONE is a single-cycle completion state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN: begin
          if (abort_hit)                   state_q <= IDLE;
          else if (pass_last && scan_last) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulation phase covers cnt 0..BLOCK_CYCLES-1; results drain one PE per cycle after it.
  assign in_acc = (cnt < CNT_W'(BLOCK_CYCLES));
  assign x_off  = cnt - CNT_W'(BLOCK_CYCLES);

  // One-hot clear and ready strobes, one bit per PE.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    assign newDist[i] = run && (cnt == CNT_W'(i));
    assign PEready[i] = run && (cnt == CNT_W'(BLOCK_CYCLES + i));
  end

  assign AddressR  = (run && in_acc)  ? ADDR_W'(cnt)  : '0;
  assign vectorX   = (run && !in_acc) ? VEC_W'(x_off) : '0;
  assign vectorY   = run ? row : '0;
  assign CompStart = run && !((row == '0) && in_acc);
  assign busy      = run;
  assign completed = (state_q == DONE);

endmodule

// File: tb/tb_me_scan_control.sv
// Randomized bench for me_scan_control with a scan-time reference model and directed pins.
module tb_me_scan_control;
  import me_pkg::*;

  localparam int unsigned NPE   = 16;
  localparam int unsigned BC    = 256;
  localparam int unsigned NR    = 16;
  localparam int unsigned PASS  = BC + NPE;
  localparam int unsigned TOTAL = NR * PASS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        CompStart, busy, completed;
  logic [15:0] PEready, newDist;
  logic [3:0]  vectorX, vectorY;
  logic [7:0]  AddressR;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned s0    = 0;

  always #5 clock = ~clock;

  me_scan_control #(.NUM_PE(NPE), .BLOCK_CYCLES(BC), .NUM_ROWS(NR)) dut (
`ifdef ME_SCAN_ABORT_EN
    .abort     (abort),
`endif
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .CompStart (CompStart),
    .PEready   (PEready),
    .vectorX   (vectorX),
    .vectorY   (vectorY),
    .newDist   (newDist),
    .AddressR  (AddressR),
    .busy      (busy),
    .completed (completed)
  );

`ifdef ME_SCAN_ABORT_EN
  logic       s_start = 1'b0, s_abort = 1'b0;
  logic       s_CompStart, s_busy, s_completed;
  logic [1:0] s_PEready, s_newDist, s_AddressR;
  logic [3:0] s_vectorX, s_vectorY;

  me_scan_control #(.NUM_PE(2), .BLOCK_CYCLES(4), .NUM_ROWS(2)) dut_small (
    .abort     (s_abort),
    .clock     (clock),
    .reset     (reset),
    .start     (s_start),
    .CompStart (s_CompStart),
    .PEready   (s_PEready),
    .vectorX   (s_vectorX),
    .vectorY   (s_vectorY),
    .newDist   (s_newDist),
    .AddressR  (s_AddressR),
    .busy      (s_busy),
    .completed (s_completed)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: m_t is the cycle index since the start edge (0 = idle, TOTAL+1 = done).
  logic abort_eff;
`ifdef ME_SCAN_ABORT_EN
  assign abort_eff = abort;
`else
  assign abort_eff = 1'b0;
`endif

  int unsigned m_t = 0;
  always @(posedge clock or posedge reset) begin
    if (reset)               m_t <= 0;
    else if (m_t == 0)       m_t <= start ? 1 : 0;
    else if (m_t <= TOTAL)   m_t <= abort_eff ? 0 : m_t + 1;
    else                     m_t <= 0;
  end

  // Compare process plus per-scan result scoreboard.
  bit          seen [16][16];
  int unsigned n_res = 0;
  int unsigned n_dup = 0;

  always @(negedge clock) begin : cmp
    int unsigned k, c, r;
    logic [31:0] e_nd, e_pr, e_ad, e_vx, e_vy;
    logic        e_cs, e_busy, e_done;
    e_nd = 0; e_pr = 0; e_ad = 0; e_vx = 0; e_vy = 0;
    e_cs = 0; e_busy = 0; e_done = 0;
    if (m_t >= 1 && m_t <= TOTAL) begin
      k = m_t - 1;
      r = k / PASS;
      c = k % PASS;
      e_busy = 1;
      e_vy   = r;
      if (c < NPE) e_nd = 32'd1 << c;
      if (c < BC) begin
        e_ad = c;
        e_cs = (r != 0);
      end else begin
        e_pr = 32'd1 << (c - BC);
        e_vx = c - BC;
        e_cs = 1;
      end
    end else if (m_t == TOTAL + 1) begin
      e_done = 1;
    end
    chk("newDist",   32'(newDist),   e_nd);
    chk("PEready",   32'(PEready),   e_pr);
    chk("AddressR",  32'(AddressR),  e_ad);
    chk("vectorX",   32'(vectorX),   e_vx);
    chk("vectorY",   32'(vectorY),   e_vy);
    chk("CompStart", 32'(CompStart), 32'(e_cs));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("completed", 32'(completed), 32'(e_done));

    if (m_t == 1) begin
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) seen[y][x] = 0;
      n_res = 0;
      n_dup = 0;
    end
    if (PEready != 0) begin
      n_res++;
      if (seen[vectorY][vectorX]) n_dup++;
      seen[vectorY][vectorX] = 1;
    end
    if (m_t == TOTAL + 1) begin
      chk("result_count", n_res, NPE * NR);
      chk("pair_dups",    n_dup, 0);
    end
  end

  task automatic to_cycle(input int unsigned n);
    while (cyc < s0 + n - 1) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic at_cycle(input int unsigned n);
    to_cycle(n);
    @(negedge clock);
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    s0 = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle.
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_newDist", 32'(newDist), 0);

    // Single scan with directed pins; start pulse at cycle 500 must be ignored.
    pulse_start();
    at_cycle(1);
    chk("c1_newDist", 32'(newDist), 32'h0001);
    chk("c1_AddressR", 32'(AddressR), 0);
    at_cycle(256);
    chk("c256_CompStart", 32'(CompStart), 0);
    chk("c256_AddressR", 32'(AddressR), 255);
    at_cycle(257);
    chk("c257_PEready", 32'(PEready), 32'h0001);
    chk("c257_vectorX", 32'(vectorX), 0);
    chk("c257_CompStart", 32'(CompStart), 1);
    at_cycle(272);
    chk("c272_PEready", 32'(PEready), 32'h8000);
    chk("c272_vectorX", 32'(vectorX), 15);
    at_cycle(273);
    chk("c273_newDist", 32'(newDist), 32'h0001);
    chk("c273_vectorY", 32'(vectorY), 1);
    to_cycle(500);
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    at_cycle(4352);
    chk("c4352_completed", 32'(completed), 0);
    at_cycle(4353);
    chk("c4353_completed", 32'(completed), 1);
    chk("c4353_CompStart", 32'(CompStart), 0);
    at_cycle(4354);
    chk("c4354_busy", 32'(busy), 0);

    // Start held high: back-to-back scans separated by one IDLE cycle.
    start = 1'b1;
    s0 = s0 + 4354;
    at_cycle(1);
    chk("held_c1_busy", 32'(busy), 1);
    at_cycle(4353);
    chk("held_done", 32'(completed), 1);
    at_cycle(4354);
    chk("held_idle", 32'(busy), 0);
    at_cycle(4355);
    chk("held_restart", 32'(newDist), 32'h0001);
    s0 = s0 + 4354;

    // Reset mid-scan at cycle 1000, then restart from row 0 / cnt 0.
    to_cycle(1000);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vectorY", 32'(vectorY), 0);
    chk("rst_CompStart", 32'(CompStart), 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    pulse_start();
    at_cycle(1);
    chk("rs_newDist", 32'(newDist), 32'h0001);
    chk("rs_vectorY", 32'(vectorY), 0);
    at_cycle(2);
    chk("rs_AddressR", 32'(AddressR), 1);

`ifdef ME_SCAN_ABORT_EN
    // Small configuration: abort at cycle 7, then an uninterrupted scan.
    @(posedge clock); #1 s_start = 1'b1;
    @(posedge clock); #1 s_start = 1'b0;
    s0 = cyc;
    at_cycle(5);
    chk("s_c5_PEready", 32'(s_PEready), 32'h1);
    at_cycle(6);
    chk("s_c6_vectorX", 32'(s_vectorX), 1);
    to_cycle(7);
    s_abort = 1'b1;
    @(negedge clock);
    chk("s_c7_busy", 32'(s_busy), 1);
    chk("s_c7_vectorY", 32'(s_vectorY), 1);
    @(posedge clock); #1 s_abort = 1'b0;
    @(negedge clock);
    chk("s_c8_busy", 32'(s_busy), 0);
    chk("s_c8_newDist", 32'(s_newDist), 0);
    for (int i = 0; i < 7; i++) begin
      chk("s_abort_nocompl", 32'(s_completed), 0);
      @(negedge clock);
    end
    @(posedge clock); #1 s_start = 1'b1;
    @(posedge clock); #1 s_start = 1'b0;
    s0 = cyc;
    at_cycle(12);
    chk("s_c12_completed", 32'(s_completed), 0);
    at_cycle(13);
    chk("s_c13_completed", 32'(s_completed), 1);
    at_cycle(14);
    chk("s_c14_busy", 32'(s_busy), 0);
`endif

    // Randomized phase.
    for (int i = 0; i < 30000; i++) begin
      @(posedge clock); #1;
      start = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 19999) == 0);
`ifdef ME_SCAN_ABORT_EN
      abort = ($urandom_range(0, 2999) == 0);
`endif
    end
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
